// File: rtl/iot_event_encoder.sv
// Serialises per-device on/off transitions into a change/on_off event stream with a shadow active count.
// Optional round-robin selection is enabled with IOT_EVT_ROUNDROBIN_EN (fixed lowest-index priority otherwise).
module iot_event_encoder #(
    parameter int N_DEV = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             resync,
    input  logic [N_DEV-1:0] dev_state,
    output logic             change,
    output logic             on_off,
    output logic [IDX_W-1:0] dev_id,
    output logic [CNT_W-1:0] active_count,
    output logic             in_sync
);

    logic [N_DEV-1:0] reported_state;
    logic [N_DEV-1:0] diff;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic [N_DEV-1:0] sel_onehot;
    logic             sel_on;

    assign diff    = dev_state ^ reported_state;
    assign in_sync = (diff == '0);
    assign sel_on  = |(dev_state & sel_onehot);

`ifdef IOT_EVT_ROUNDROBIN_EN
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_next;

    // Scan diff starting at ptr, wrapping at N_DEV (which need not be a power of two).
    always_comb begin
        int idx;
        sel_valid  = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        idx        = 0;
        for (int j = 0; j < N_DEV; j++) begin
            idx = int'(ptr) + j;
            if (idx >= N_DEV) begin
                idx = idx - N_DEV;
            end
            if (!sel_valid && diff[idx]) begin
                sel_valid  = 1'b1;
                sel_idx    = IDX_W'(idx);
                sel_onehot = N_DEV'(1) << idx;
            end
        end
    end

    assign ptr_next = (int'(sel_idx) == N_DEV - 1) ? '0 : sel_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst || resync) begin
            ptr <= '0;
        end else if (enable && sel_valid) begin
            ptr <= ptr_next;
        end
    end
`else
    always_comb begin
        sel_valid  = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (!sel_valid && diff[i]) begin
                sel_valid  = 1'b1;
                sel_idx    = IDX_W'(i);
                sel_onehot = N_DEV'(1) << i;
            end
        end
    end
`endif

    // The selected bit is known to differ, so flipping it copies dev_state into reported_state.
    always_ff @(posedge clk) begin
        if (rst || resync) begin
            reported_state <= '0;
            change         <= 1'b0;
            on_off         <= 1'b0;
            dev_id         <= '0;
            active_count   <= '0;
        end else if (enable && sel_valid) begin
            reported_state <= reported_state ^ sel_onehot;
            change         <= 1'b1;
            on_off         <= sel_on;
            dev_id         <= sel_idx;
            if (sel_on) begin
                active_count <= active_count + CNT_W'(1);
            end else begin
                active_count <= active_count - CNT_W'(1);
            end
        end else begin
            change <= 1'b0;
            on_off <= 1'b0;
            dev_id <= '0;
        end
    end

endmodule
